// File: rtl/udma_jtag_rx_packer.sv
// Packs 8/16/32-bit JTAG RX beats little-endian into 32-bit words and queues
// them, with flush to emit a trailing partial word and its valid-byte count.
module udma_jtag_rx_packer #(
  parameter int DEPTH = 4
) (
  input  logic                       jtag_tck_i,
  input  logic                       jtag_trstn_i,
  input  logic [31:0]                data_i,
  input  logic [1:0]                 data_size_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  input  logic                       flush_i,
  output logic                       flush_ack_o,
  output logic [31:0]                data_o,
  output logic [2:0]                 data_bytes_o,
  output logic                       data_valid_o,
  input  logic                       data_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       err_size_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bytes;
  } entry_t;

  logic [31:0] acc, acc_nxt, beat;
  logic [1:0]  bcnt, bcnt_nxt;
  logic [2:0]  nb, sum;
  logic [63:0] ext;
  logic        rsvd, accept, full, empty, push, pop;
  entry_t      push_e;
  entry_t      mem [DEPTH];
  logic [AW:0] wptr, rptr;

  assign level_o      = LW'(wptr - rptr);
  assign full         = (level_o == LW'(DEPTH));
  assign empty        = (wptr == rptr);
  assign data_valid_o = !empty;
  assign data_ready_o = !full && !flush_i;
  assign accept       = data_valid_i && data_ready_o;
  assign flush_ack_o  = flush_i && ((bcnt == 2'd0) || !full);
  assign pop          = !empty && data_ready_i;
  assign data_o       = mem[rptr[AW-1:0]].data;
  assign data_bytes_o = mem[rptr[AW-1:0]].bytes;

  always_comb begin
    rsvd = (data_size_i == 2'b11);
    case (data_size_i)
      2'b00:   begin nb = 3'd1; beat = {24'b0, data_i[7:0]};  end
      2'b01:   begin nb = 3'd2; beat = {16'b0, data_i[15:0]}; end
      default: begin nb = 3'd4; beat = data_i;                end
    endcase
    // Upper half of ext holds bytes that spill past the word being completed.
    ext      = {32'b0, acc} | ({32'b0, beat} << {bcnt, 3'b000});
    sum      = {1'b0, bcnt} + nb;
    push     = 1'b0;
    push_e   = '0;
    acc_nxt  = acc;
    bcnt_nxt = bcnt;
    if (accept && !rsvd) begin
      bcnt_nxt = sum[1:0];
      if (sum[2]) begin
        push    = 1'b1;
        push_e  = '{data: ext[31:0], bytes: 3'd4};
        acc_nxt = ext[63:32];
      end else begin
        acc_nxt = ext[31:0];
      end
    end else if (flush_ack_o && (bcnt != 2'd0)) begin
      push     = 1'b1;
      push_e   = '{data: acc, bytes: {1'b0, bcnt}};
      acc_nxt  = '0;
      bcnt_nxt = '0;
    end
  end

  always_ff @(posedge jtag_tck_i or negedge jtag_trstn_i) begin
    if (!jtag_trstn_i) begin
      acc        <= '0;
      bcnt       <= '0;
      wptr       <= '0;
      rptr       <= '0;
      err_size_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      acc        <= acc_nxt;
      bcnt       <= bcnt_nxt;
      err_size_o <= accept && rsvd;
      if (push) mem[wptr[AW-1:0]] <= push_e;
      wptr <= wptr + (AW+1)'(push);
      rptr <= rptr + (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_udma_jtag_rx_packer.sv
// Directed per-cycle vector bench for the JTAG RX packer; inputs driven on the
// falling edge, outputs compared just before the next rising edge.
module tb_udma_jtag_rx_packer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] data_i = '0;
  logic [1:0]  data_size_i = '0;
  logic        data_valid_i = 1'b0, flush_i = 1'b0, data_ready_i = 1'b0;
  logic        data_ready_o, flush_ack_o, data_valid_o, err_size_o;
  logic [31:0] data_o;
  logic [2:0]  data_bytes_o, level_o;

  udma_jtag_rx_packer #(.DEPTH(4)) dut (
    .jtag_tck_i(clk), .jtag_trstn_i(rst_n),
    .data_i(data_i), .data_size_i(data_size_i), .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
    .data_o(data_o), .data_bytes_o(data_bytes_o), .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i), .level_o(level_o), .err_size_o(err_size_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [1:0]  sz;
    logic [31:0] d;
    logic        fl, rdy;
    logic        e_rdy, e_ack, e_dv;
    logic [31:0] e_data;
    logic [2:0]  e_bytes, e_lvl;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0, n_bad = 0;

  function automatic vec_t mk(logic vld, logic [1:0] sz, logic [31:0] d, logic fl, logic rdy,
                              logic e_rdy, logic e_ack, logic e_dv, logic [31:0] e_data,
                              logic [2:0] e_bytes, logic [2:0] e_lvl, logic e_err);
    vec_t v;
    v.vld = vld; v.sz = sz; v.d = d; v.fl = fl; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_ack = e_ack; v.e_dv = e_dv; v.e_data = e_data;
    v.e_bytes = e_bytes; v.e_lvl = e_lvl; v.e_err = e_err;
    return v;
  endfunction

  // Idle cycle helper: only rdy and expected queue view vary.
  function automatic vec_t idle(logic rdy, logic e_rdy, logic e_dv, logic [31:0] e_data,
                                logic [2:0] e_bytes, logic [2:0] e_lvl);
    return mk(0, 2'b00, 32'h0, 0, rdy, e_rdy, 0, e_dv, e_data, e_bytes, e_lvl, 0);
  endfunction

  task automatic drive(input vec_t v);
    data_valid_i = v.vld; data_size_i = v.sz; data_i = v.d;
    flush_i = v.fl; data_ready_i = v.rdy;
  endtask

  task automatic check(input string name, input vec_t v);
    logic bad;
    n_vec++;
    bad = (data_ready_o !== v.e_rdy) || (flush_ack_o !== v.e_ack) ||
          (data_valid_o !== v.e_dv) || (level_o !== v.e_lvl) || (err_size_o !== v.e_err) ||
          (v.e_dv && ((data_o !== v.e_data) || (data_bytes_o !== v.e_bytes)));
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b ack=%b dv=%b data=%h bytes=%0d lvl=%0d err=%b, want rdy=%b ack=%b dv=%b data=%h bytes=%0d lvl=%0d err=%b",
               name, data_ready_o, flush_ack_o, data_valid_o, data_o, data_bytes_o, level_o, err_size_o,
               v.e_rdy, v.e_ack, v.e_dv, v.e_data, v.e_bytes, v.e_lvl, v.e_err);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    @(negedge clk);
    drive(v);
    #4;
    check(name, v);
  endtask

  task automatic chk_zero(input string name);
    n_vec++;
    if (data_o !== 32'h0 || data_bytes_o !== 3'd0) begin
      n_bad++;
      $display("FAIL %s: got data=%h bytes=%0d, want data=00000000 bytes=0", name, data_o, data_bytes_o);
    end
  endtask

  initial begin
    // 8b x4 -> 0x44332211
    tbl.push_back(mk(1, 2'b00, 32'h11, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 32'h22, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 32'h33, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 32'h44, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 1, 32'h44332211, 4, 1));
    // 8b AA, 32b 44332211, flush -> 332211AA / 00000044 b1
    tbl.push_back(mk(1, 2'b00, 32'hAA, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 32'h44332211, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 32'h0, 1, 0, 0, 1, 1, 32'h332211AA, 4, 1, 0));
    tbl.push_back(idle(1, 1, 1, 32'h332211AA, 4, 2));
    tbl.push_back(idle(1, 1, 1, 32'h00000044, 1, 1));
    tbl.push_back(idle(0, 1, 0, 0, 0, 0));
    // reserved size, then BEEF + CAFE
    tbl.push_back(mk(1, 2'b11, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b01, 32'h1234BEEF, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 2'b01, 32'hFFFFCAFE, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 1, 32'hCAFEBEEF, 4, 1));
    tbl.push_back(idle(0, 1, 0, 0, 0, 0));
    // fill queue, 5th beat stalls, no bypass on pop-while-full
    tbl.push_back(mk(1, 2'b10, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 32'h1, 0, 0, 1, 0, 1, 32'h0, 4, 1, 0));
    tbl.push_back(mk(1, 2'b10, 32'h2, 0, 0, 1, 0, 1, 32'h0, 4, 2, 0));
    tbl.push_back(mk(1, 2'b10, 32'h3, 0, 0, 1, 0, 1, 32'h0, 4, 3, 0));
    tbl.push_back(mk(1, 2'b10, 32'h4, 0, 0, 0, 0, 1, 32'h0, 4, 4, 0));
    tbl.push_back(mk(1, 2'b10, 32'h4, 0, 1, 0, 0, 1, 32'h0, 4, 4, 0));
    tbl.push_back(mk(1, 2'b10, 32'h4, 0, 0, 1, 0, 1, 32'h1, 4, 3, 0));
    tbl.push_back(idle(1, 0, 1, 32'h1, 4, 4));
    tbl.push_back(idle(1, 1, 1, 32'h2, 4, 3));
    tbl.push_back(idle(1, 1, 1, 32'h3, 4, 2));
    tbl.push_back(idle(1, 1, 1, 32'h4, 4, 1));
    tbl.push_back(idle(0, 1, 0, 0, 0, 0));
    // flush with nothing pending acks immediately
    tbl.push_back(mk(0, 2'b00, 32'h0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    // bcnt=2 with a full queue: flush waits for a pop
    tbl.push_back(mk(1, 2'b01, 32'h5566, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 32'hA3A2A1A0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 32'hB3B2B1B0, 0, 0, 1, 0, 1, 32'hA1A05566, 4, 1, 0));
    tbl.push_back(mk(1, 2'b10, 32'hC3C2C1C0, 0, 0, 1, 0, 1, 32'hA1A05566, 4, 2, 0));
    tbl.push_back(mk(1, 2'b10, 32'hD3D2D1D0, 0, 0, 1, 0, 1, 32'hA1A05566, 4, 3, 0));
    tbl.push_back(mk(0, 2'b00, 32'h0, 1, 0, 0, 0, 1, 32'hA1A05566, 4, 4, 0));
    tbl.push_back(mk(0, 2'b00, 32'h0, 1, 1, 0, 0, 1, 32'hA1A05566, 4, 4, 0));
    tbl.push_back(mk(0, 2'b00, 32'h0, 1, 0, 0, 1, 1, 32'hB1B0A3A2, 4, 3, 0));
    tbl.push_back(idle(1, 0, 1, 32'hB1B0A3A2, 4, 4));
    tbl.push_back(idle(1, 1, 1, 32'hC1C0B3B2, 4, 3));
    tbl.push_back(idle(1, 1, 1, 32'hD1D0C3C2, 4, 2));
    tbl.push_back(idle(1, 1, 1, 32'h0000D3D2, 2, 1));
    tbl.push_back(idle(0, 1, 0, 0, 0, 0));

    // reset state
    #3;
    check("reset", idle(0, 1, 0, 0, 0, 0));
    chk_zero("reset_data");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // mid-operation reset with bcnt=2 and two words queued
    apply("pre_rst0", mk(1, 2'b01, 32'h1111, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply("pre_rst1", mk(1, 2'b10, 32'h22222222, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply("pre_rst2", mk(1, 2'b10, 32'h33333333, 0, 0, 1, 0, 1, 32'h22221111, 4, 1, 0));
    apply("pre_rst3", idle(0, 1, 1, 32'h22221111, 4, 2));
    rst_n = 1'b0;
    #1;
    check("mid_rst", idle(0, 1, 0, 0, 0, 0));
    chk_zero("mid_rst_data");
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst0", mk(1, 2'b10, 32'h12345678, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply("post_rst1", idle(0, 1, 1, 32'h12345678, 4, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
